digit_scan_convert: RTL and testbench

//  Parametrised scanner over a DEPTH x WIDTH register file reached through an

---
 rtl/digit_scan_convert.sv | 154 +++++++++++++++
 tb/tb_digit_scan_convert.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/digit_scan_convert.sv
// Scans a DEPTH x WIDTH register file through an external port, counting ASCII
// digits and optionally rewriting each digit in place as its binary value.
module digit_scan_convert #(
  parameter int DEPTH  = 16,
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              go,
  input  logic [1:0]        mode,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [WIDTH-1:0]  mem_rd_data,
  output logic              mem_wr_en,
  output logic [WIDTH-1:0]  mem_wr_data,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   count,
  output logic [ADDR_W+3:0] sum
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    WAIT = 3'd2,
    EVAL = 3'd3,
    WR   = 3'd4,
    DONE = 3'd5
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
  localparam logic [WIDTH-1:0]  CH_0     = WIDTH'(8'h30);
  localparam logic [WIDTH-1:0]  CH_9     = WIDTH'(8'h39);
  localparam logic [WIDTH-1:0]  CH_UA    = WIDTH'(8'h41);
  localparam logic [WIDTH-1:0]  CH_UF    = WIDTH'(8'h46);
  localparam logic [WIDTH-1:0]  CH_LA    = WIDTH'(8'h61);
  localparam logic [WIDTH-1:0]  CH_LF    = WIDTH'(8'h66);

  state_t              state_r;
  state_t              next_s;
  logic [ADDR_W-1:0]   idx_r;
  logic [WIDTH-1:0]    temp_r;
  logic [1:0]          mode_r;
  logic [ADDR_W:0]     count_r;
  logic [ADDR_W+3:0]   sum_r;
  logic                busy_r;
  logic                done_r;

  logic                is_dec_s;
  logic                is_hex_s;
  logic                is_digit_s;
  logic                convert_s;
  logic                last_s;
  logic [3:0]          val_s;

  // Full-width compares, so any set upper bit disqualifies the entry.
  assign is_dec_s   = (temp_r >= CH_0) && (temp_r <= CH_9);
  assign is_hex_s   = ((temp_r >= CH_UA) && (temp_r <= CH_UF)) ||
                      ((temp_r >= CH_LA) && (temp_r <= CH_LF));
  assign is_digit_s = is_dec_s || ((mode_r == 2'b10) && is_hex_s);
  assign convert_s  = (mode_r == 2'b01) || (mode_r == 2'b10);
  assign last_s     = (idx_r == LAST_IDX);
  // Letters A-F/a-f carry 1..6 in the low nibble, hence the +9.
  assign val_s      = is_dec_s ? temp_r[3:0] : (temp_r[3:0] + 4'd9);

  assign busy  = busy_r;
  assign done  = done_r;
  assign count = count_r;
  assign sum   = sum_r;

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and memory port strobes, gated off during reset.
  always_comb begin
    next_s      = state_r;
    mem_addr    = idx_r;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wr_data = {{(WIDTH-4){1'b0}}, val_s};
    case (state_r)
      IDLE: begin
        if (go) next_s = RD;
        else    next_s = IDLE;
      end
      RD: begin
        mem_rd_en = ~Rst;
        next_s    = WAIT;
      end
      WAIT: next_s = EVAL;
      EVAL: begin
        if (is_digit_s && convert_s) next_s = WR;
        else if (last_s)             next_s = DONE;
        else                         next_s = RD;
      end
      WR: begin
        mem_wr_en = ~Rst;
        if (last_s) next_s = DONE;
        else        next_s = RD;
      end
      DONE: begin
        if (go) next_s = RD;
        else    next_s = DONE;
      end
      default: next_s = IDLE;
    endcase
  end

  // Index, latched data/mode, totals and status flags.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      idx_r   <= '0;
      temp_r  <= '0;
      mode_r  <= 2'b00;
      count_r <= '0;
      sum_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (next_s == RD) || (next_s == WAIT) || (next_s == EVAL) || (next_s == WR);
      done_r <= (next_s == DONE);
      case (state_r)
        IDLE, DONE: begin
          if (go) begin
            idx_r   <= '0;
            count_r <= '0;
            sum_r   <= '0;
            mode_r  <= mode;
          end
        end
        WAIT: temp_r <= mem_rd_data;
        EVAL: begin
          if (is_digit_s) begin
            count_r <= count_r + {{ADDR_W{1'b0}}, 1'b1};
            sum_r   <= sum_r + {{ADDR_W{1'b0}}, val_s};
          end
          if (next_s == RD) idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        WR: begin
          if (next_s == RD) idx_r <= idx_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_digit_scan_convert.sv
// Directed bench for digit_scan_convert: a 16x8 instance and a 4x16 instance,
// each backed by a simple registered-read memory model with a write log.
module tb_digit_scan_convert;

  logic Clk = 1'b0;
  logic Rst;
  always #5 Clk = ~Clk;

  // 16 x 8 instance
  logic        go_a;
  logic [1:0]  mode_a;
  logic [3:0]  addr_a;
  logic        rd_en_a, wr_en_a, busy_a, done_a;
  logic [7:0]  rd_data_a, wr_data_a;
  logic [4:0]  count_a;
  logic [7:0]  sum_a;

  // 4 x 16 instance
  logic        go_b;
  logic [1:0]  mode_b;
  logic [1:0]  addr_b;
  logic        rd_en_b, wr_en_b, busy_b, done_b;
  logic [15:0] rd_data_b, wr_data_b;
  logic [2:0]  count_b;
  logic [5:0]  sum_b;

  digit_scan_convert #(.DEPTH(16), .WIDTH(8), .ADDR_W(4)) u_dut_a (
    .Clk(Clk), .Rst(Rst), .go(go_a), .mode(mode_a),
    .mem_addr(addr_a), .mem_rd_en(rd_en_a), .mem_rd_data(rd_data_a),
    .mem_wr_en(wr_en_a), .mem_wr_data(wr_data_a),
    .busy(busy_a), .done(done_a), .count(count_a), .sum(sum_a)
  );

  digit_scan_convert #(.DEPTH(4), .WIDTH(16), .ADDR_W(2)) u_dut_b (
    .Clk(Clk), .Rst(Rst), .go(go_b), .mode(mode_b),
    .mem_addr(addr_b), .mem_rd_en(rd_en_b), .mem_rd_data(rd_data_b),
    .mem_wr_en(wr_en_b), .mem_wr_data(wr_data_b),
    .busy(busy_b), .done(done_b), .count(count_b), .sum(sum_b)
  );

  logic [7:0]  img_a [0:15];
  logic [7:0]  mem_a [0:15];
  logic        load_a = 1'b0;
  int          nwr_a = 0;
  logic [3:0]  wlog_addr_a [0:63];
  logic [7:0]  wlog_data_a [0:63];

  logic [15:0] img_b [0:3];
  logic [15:0] mem_b [0:3];
  logic        load_b = 1'b0;
  int          nwr_b = 0;
  logic [1:0]  wlog_addr_b [0:7];
  logic [15:0] wlog_data_b [0:7];

  always @(posedge Clk) begin
    if (load_a) mem_a <= img_a;
    else if (wr_en_a) begin
      mem_a[addr_a] <= wr_data_a;
      if (nwr_a < 64) begin
        wlog_addr_a[nwr_a] <= addr_a;
        wlog_data_a[nwr_a] <= wr_data_a;
      end
      nwr_a <= nwr_a + 1;
    end
    if (rd_en_a) rd_data_a <= mem_a[addr_a];
  end

  always @(posedge Clk) begin
    if (load_b) mem_b <= img_b;
    else if (wr_en_b) begin
      mem_b[addr_b] <= wr_data_b;
      if (nwr_b < 8) begin
        wlog_addr_b[nwr_b] <= addr_b;
        wlog_data_b[nwr_b] <= wr_data_b;
      end
      nwr_b <= nwr_b + 1;
    end
    if (rd_en_b) rd_data_b <= mem_b[addr_b];
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_load_a();
    load_a = 1'b1;
    @(posedge Clk); #1;
    load_a = 1'b0;
  endtask

  // Pulse (or hold) go, then count clocks from the sampling edge until done.
  task automatic run_scan_a(input logic [1:0] m, input bit hold, output int lat,
                            output logic [4:0] first_rd);
    mode_a = m;
    go_a   = 1'b1;
    @(posedge Clk); #1;
    lat      = 1;
    first_rd = {rd_en_a, addr_a};
    if (!hold) go_a = 1'b0;
    while (!done_a && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
  endtask

  int         lat, base, k;
  logic [4:0] first_rd;

  initial begin
    Rst = 1'b1; go_a = 1'b0; go_b = 1'b0; mode_a = 2'b00; mode_b = 2'b00;
    for (int i = 0; i < 16; i++) img_a[i] = 8'h00;
    for (int i = 0; i < 4; i++)  img_b[i] = 16'h0000;
    repeat (2) @(posedge Clk);
    #1;
    chk("rst_busy",  32'(busy_a),  32'd0);
    chk("rst_done",  32'(done_a),  32'd0);
    chk("rst_count", 32'(count_a), 32'd0);
    chk("rst_sum",   32'(sum_a),   32'd0);
    chk("rst_rd_en", 32'(rd_en_a), 32'd0);
    Rst = 1'b0;

    // 1: "x7y3zz9q", count only
    img_a[0] = 8'h78; img_a[1] = 8'h37; img_a[2] = 8'h79; img_a[3] = 8'h33;
    img_a[4] = 8'h7A; img_a[5] = 8'h7A; img_a[6] = 8'h39; img_a[7] = 8'h71;
    do_load_a();
    base = nwr_a;
    run_scan_a(2'b00, 1'b0, lat, first_rd);
    chk("t1_first_rd", 32'(first_rd), 32'h10);
    chk("t1_latency",  32'(lat), 32'd49);
    chk("t1_count",    32'(count_a), 32'd3);
    chk("t1_sum",      32'(sum_a), 32'd19);
    chk("t1_writes",   32'(nwr_a - base), 32'd0);
    chk("t1_busy_off", 32'(busy_a), 32'd0);

    // 2: same image, convert decimal
    base = nwr_a;
    run_scan_a(2'b01, 1'b0, lat, first_rd);
    chk("t2_latency", 32'(lat), 32'd52);
    chk("t2_count",   32'(count_a), 32'd3);
    chk("t2_sum",     32'(sum_a), 32'd19);
    chk("t2_writes",  32'(nwr_a - base), 32'd3);
    chk("t2_w0", {20'd0, wlog_addr_a[base],   wlog_data_a[base]},   32'h107);
    chk("t2_w1", {20'd0, wlog_addr_a[base+1], wlog_data_a[base+1]}, 32'h303);
    chk("t2_w2", {20'd0, wlog_addr_a[base+2], wlog_data_a[base+2]}, 32'h609);
    chk("t2_mem0_kept", 32'(mem_a[0]), 32'h78);

    // 3: "FaG9", hex convert
    for (int i = 0; i < 16; i++) img_a[i] = 8'h00;
    img_a[0] = 8'h46; img_a[1] = 8'h61; img_a[2] = 8'h47; img_a[3] = 8'h39;
    do_load_a();
    base = nwr_a;
    run_scan_a(2'b10, 1'b0, lat, first_rd);
    chk("t3_latency", 32'(lat), 32'd52);
    chk("t3_count",   32'(count_a), 32'd3);
    chk("t3_sum",     32'(sum_a), 32'd34);
    chk("t3_writes",  32'(nwr_a - base), 32'd3);
    chk("t3_w0", {20'd0, wlog_addr_a[base],   wlog_data_a[base]},   32'h00F);
    chk("t3_w1", {20'd0, wlog_addr_a[base+1], wlog_data_a[base+1]}, 32'h10A);
    chk("t3_w2", {20'd0, wlog_addr_a[base+2], wlog_data_a[base+2]}, 32'h309);
    chk("t3_mem2_kept", 32'(mem_a[2]), 32'h47);

    // 4: all '9', full count width
    for (int i = 0; i < 16; i++) img_a[i] = 8'h39;
    do_load_a();
    base = nwr_a;
    run_scan_a(2'b01, 1'b0, lat, first_rd);
    chk("t4_latency", 32'(lat), 32'd65);
    chk("t4_count",   32'(count_a), 32'd16);
    chk("t4_sum",     32'(sum_a), 32'd144);
    chk("t4_writes",  32'(nwr_a - base), 32'd16);
    chk("t4_w15", {20'd0, wlog_addr_a[base+15], wlog_data_a[base+15]}, 32'hF09);

    // 5: reset while writing idx 5, then rescan
    for (int i = 0; i < 16; i++) img_a[i] = 8'h35;
    do_load_a();
    base = nwr_a;
    mode_a = 2'b01; go_a = 1'b1;
    @(posedge Clk); #1;
    go_a = 1'b0;
    k = 0;
    while (!(wr_en_a && addr_a == 4'd5) && k < 200) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("t5_reached_wr5", 32'(k < 200), 32'd1);
    Rst = 1'b1;
    #1;
    chk("t5_wr_gated", 32'(wr_en_a), 32'd0);
    @(posedge Clk); #1;
    Rst = 1'b0;
    chk("t5_mem5_kept", 32'(mem_a[5]), 32'h35);
    chk("t5_mem4_conv", 32'(mem_a[4]), 32'h05);
    chk("t5_pre_writes", 32'(nwr_a - base), 32'd5);
    chk("t5_outs", {26'd0, busy_a, done_a, count_a[3:0]}, 32'd0);
    chk("t5_sum0", 32'(sum_a), 32'd0);
    base = nwr_a;
    run_scan_a(2'b01, 1'b0, lat, first_rd);
    chk("t5_first_rd", 32'(first_rd), 32'h10);
    chk("t5_latency",  32'(lat), 32'd60);
    chk("t5_count",    32'(count_a), 32'd11);
    chk("t5_sum",      32'(sum_a), 32'd55);
    chk("t5_writes",   32'(nwr_a - base), 32'd11);
    chk("t5_first_w",  32'(wlog_addr_a[base]), 32'd5);

    // 6a: go held, mode 11 acts as count-only, restart from DONE ignores new mode
    img_a[0] = 8'h78; img_a[1] = 8'h37; img_a[2] = 8'h79; img_a[3] = 8'h33;
    img_a[4] = 8'h7A; img_a[5] = 8'h7A; img_a[6] = 8'h39; img_a[7] = 8'h71;
    for (int i = 8; i < 16; i++) img_a[i] = 8'h00;
    do_load_a();
    base = nwr_a;
    run_scan_a(2'b11, 1'b1, lat, first_rd);
    chk("t6_latency", 32'(lat), 32'd49);
    chk("t6_count",   32'(count_a), 32'd3);
    chk("t6_sum",     32'(sum_a), 32'd19);
    @(posedge Clk); #1;
    chk("t6_restart", {28'd0, busy_a, done_a, rd_en_a, 1'b0}, 32'hA);
    chk("t6_restart_addr", 32'(addr_a), 32'd0);
    mode_a = 2'b01;
    go_a   = 1'b0;
    k = 0;
    while (!done_a && k < 200) begin
      @(posedge Clk); #1;
      k++;
    end
    chk("t6_rescan_count", 32'(count_a), 32'd3);
    chk("t6_no_writes",    32'(nwr_a - base), 32'd0);

    // 6b: 16-bit entries, 0x0130 must not be taken for '0'
    img_b[0] = 16'h0130; img_b[1] = 16'h0031; img_b[2] = 16'h0041; img_b[3] = 16'h0039;
    load_b = 1'b1;
    @(posedge Clk); #1;
    load_b = 1'b0;
    mode_b = 2'b01; go_b = 1'b1;
    @(posedge Clk); #1;
    go_b = 1'b0;
    lat = 1;
    while (!done_b && lat < 200) begin
      @(posedge Clk); #1;
      lat++;
    end
    chk("t6b_latency", 32'(lat), 32'd15);
    chk("t6b_count",   32'(count_b), 32'd2);
    chk("t6b_sum",     32'(sum_b), 32'd10);
    chk("t6b_writes",  32'(nwr_b), 32'd2);
    chk("t6b_w0", {14'd0, wlog_addr_b[0], wlog_data_b[0]}, 32'h10001);
    chk("t6b_w1", {14'd0, wlog_addr_b[1], wlog_data_b[1]}, 32'h30009);
    chk("t6b_mem0_kept", 32'(mem_b[0]), 32'h0130);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
